// File: rtl/div_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : div_arbiter_if
//  Purpose  : Request/response and divider handshake bundle for div_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface div_arbiter_if #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_signed;
    logic [NREQ*32-1:0] req_x;
    logic [NREQ*32-1:0] req_y;
    logic [NREQ-1:0]    req_flush;
    logic               resp_valid;
    logic               resp_ready;
    logic [ID_W-1:0]    resp_id;
    logic [31:0]        resp_q;
    logic [31:0]        resp_r;
    logic               dv_div;
    logic               dv_signed;
    logic [31:0]        dv_x;
    logic [31:0]        dv_y;
    logic               dv_tready;
    logic [31:0]        dv_s;
    logic [31:0]        dv_r;
    logic               dv_complete;

    // slave: the arbiter itself; master: requesters, consumer and divider
    modport slave (
        input  req_valid, req_signed, req_x, req_y, req_flush, resp_ready,
               dv_tready, dv_s, dv_r, dv_complete,
        output req_ready, resp_valid, resp_id, resp_q, resp_r,
               dv_div, dv_signed, dv_x, dv_y
    );
    modport master (
        output req_valid, req_signed, req_x, req_y, req_flush, resp_ready,
               dv_tready, dv_s, dv_r, dv_complete,
        input  req_ready, resp_valid, resp_id, resp_q, resp_r,
               dv_div, dv_signed, dv_x, dv_y
    );
endinterface
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : div_arbiter
//  Purpose  : Round-robin sharing of one iterative 32/32 divider between NREQ
//             requesters, with tagged response and per-owner flush.
//             Optional: DIV_ZERO_BYPASS_EN answers y==0 without the divider.
//  Revision : 1.0  initial release
// ============================================================================
module div_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  wire            clk,
    input  wire            rst,
    div_arbiter_if.slave   bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;
    localparam logic [1:0] c_st_resp  = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    // r_owner doubles as the round-robin pointer: it always holds the last grant
    logic [ID_W-1:0] r_owner;
    logic            r_signed;
    logic [31:0]     r_x;
    logic [31:0]     r_y;
    logic            r_kill;
    logic            r_wait_first;
    logic [31:0]     r_resp_q;
    logic [31:0]     r_resp_r;

    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_ready;
    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_gidx;
    logic            w_found;
    logic [31:0]     w_sel_x;
    logic [31:0]     w_sel_y;
    logic            w_sel_s;
    logic            w_flush_own;
    logic            w_take;
    logic            w_capture;
    logic            w_kill_set;
`ifdef DIV_ZERO_BYPASS_EN
    logic            w_bypass;
`endif

    assign w_cand = bus.req_valid & ~bus.req_flush;

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = r_owner;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + ID_W'(1);
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    always_comb begin
        w_ready     = '0;
        w_sel_x     = '0;
        w_sel_y     = '0;
        w_sel_s     = 1'b0;
        w_flush_own = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == ID_W'(i)) begin
                w_sel_x = bus.req_x[32*i +: 32];
                w_sel_y = bus.req_y[32*i +: 32];
                w_sel_s = bus.req_signed[i];
                if (r_state == c_st_idle && w_found) begin
                    w_ready[i] = 1'b1;
                end
            end
            if (r_owner == ID_W'(i)) begin
                w_flush_own = bus.req_flush[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_capture   = 1'b0;
        w_kill_set  = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        w_bypass    = 1'b0;
`endif
        case (r_state)
            c_st_idle: begin
                if (w_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = c_st_issue;
`ifdef DIV_ZERO_BYPASS_EN
                    if (w_sel_y == 32'd0) begin
                        w_bypass    = 1'b1;
                        w_state_nxt = c_st_resp;
                    end
`endif
                end
            end
            c_st_issue: begin
                // once accepted the op cannot be recalled, so a late flush becomes a kill
                if (bus.dv_tready) begin
                    w_state_nxt = c_st_wait;
                    w_kill_set  = w_flush_own;
                end else if (w_flush_own) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_wait: begin
                w_kill_set = w_flush_own;
                if (!r_wait_first && bus.dv_complete) begin
                    if (r_kill || w_flush_own) begin
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_state_nxt = c_st_resp;
                        w_capture   = 1'b1;
                    end
                end
            end
            default: begin
                if (bus.resp_ready || w_flush_own) begin
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= '0;
            r_signed     <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_kill       <= 1'b0;
            r_wait_first <= 1'b0;
            r_resp_q     <= '0;
            r_resp_r     <= '0;
        end else begin
            if (w_take) begin
                r_owner  <= w_gidx;
                r_signed <= w_sel_s;
                r_x      <= w_sel_x;
                r_y      <= w_sel_y;
            end
            r_wait_first <= (r_state == c_st_issue) && (w_state_nxt == c_st_wait);
            if (w_state_nxt == c_st_idle) begin
                r_kill <= 1'b0;
            end else if (w_kill_set) begin
                r_kill <= 1'b1;
            end
            if (w_capture) begin
                r_resp_q <= bus.dv_s;
                r_resp_r <= bus.dv_r;
            end
`ifdef DIV_ZERO_BYPASS_EN
            if (w_bypass) begin
                r_resp_q <= 32'hFFFF_FFFF;
                r_resp_r <= w_sel_x;
            end
`endif
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = (r_state == c_st_resp);
    assign bus.resp_id    = r_owner;
    assign bus.resp_q     = r_resp_q;
    assign bus.resp_r     = r_resp_r;
    assign bus.dv_div     = (r_state == c_st_issue);
    assign bus.dv_signed  = r_signed;
    assign bus.dv_x       = r_x;
    assign bus.dv_y       = r_y;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_arbiter
//  Purpose  : Directed self-checking bench for div_arbiter with a divider model
//             and an in-order response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_arbiter;
    localparam int NREQ = 2;
    localparam int ID_W = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus();
    div_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic [ID_W-1:0] id;
        logic [31:0]     q;
        logic [31:0]     r;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   n_acc = 0;
    int   n_cmp = 0;
    int   snap;
    logic m_tready;
    int   m_cnt;
    logic [31:0] m_q, m_r;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] q, r;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else if (sgn) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        return {q, r};
    endfunction

    // Divider model: completion stays high one cycle past acceptance, ~34-cycle op
    assign bus.dv_tready = m_tready;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt           <= 0;
            bus.dv_complete <= 1'b1;
            bus.dv_s        <= '0;
            bus.dv_r        <= '0;
        end else if (m_cnt == 0) begin
            if (bus.dv_div && m_tready) begin
                m_cnt      <= 35;
                {m_q, m_r} <= ref_div(bus.dv_signed, bus.dv_x, bus.dv_y);
                n_acc      <= n_acc + 1;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 35) bus.dv_complete <= 1'b0;
            if (m_cnt == 1) begin
                bus.dv_complete <= 1'b1;
                bus.dv_s        <= m_q;
                bus.dv_r        <= m_r;
                n_cmp           <= n_cmp + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", {63'd0, bus.resp_valid}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_id", {63'd0, bus.resp_id}, {63'd0, mon_e.id});
                check("resp_q", {32'd0, bus.resp_q}, {32'd0, mon_e.q});
                check("resp_r", {32'd0, bus.resp_r}, {32'd0, mon_e.r});
            end
        end
    end

    task automatic push_exp(input logic [ID_W-1:0] id, input logic [31:0] q, input logic [31:0] r);
        exp_t e;
        e.id = id;
        e.q  = q;
        e.r  = r;
        sb.push_back(e);
    endtask

    task automatic drive(input int lane, input logic sgn, input logic [31:0] x, input logic [31:0] y);
        bus.req_signed[lane]     = sgn;
        bus.req_x[32*lane +: 32] = x;
        bus.req_y[32*lane +: 32] = y;
    endtask

    task automatic wait_ready(input string tag, input logic [NREQ-1:0] exp);
        int n = 0;
        #1;
        while (bus.req_ready == '0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, {62'd0, bus.req_ready}, {62'd0, exp});
    endtask

    task automatic wait_resp_valid(input string tag);
        int n = 0;
        while (!bus.resp_valid && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, {63'd0, bus.resp_valid}, 64'd1);
    endtask

    task automatic wait_sb_empty(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {59'd0, bus.req_ready, bus.resp_valid, bus.dv_div, bus.dv_signed, bus.resp_id}, 64'd0);
        check({tag, "_resp"}, {bus.resp_q, bus.resp_r}, 64'd0);
        check({tag, "_dvop"}, {bus.dv_x, bus.dv_y}, 64'd0);
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_signed = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_flush  = '0;
        bus.resp_ready = 1'b1;
        m_tready       = 1'b1;
        #1 rst = 1'b1;
        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: unsigned 100/7 on lane 0
        @(negedge clk); #1;
        drive(0, 1'b0, 32'd100, 32'd7);
        bus.req_valid = 2'b01;
        push_exp(1'b0, 32'd14, 32'd2);
        wait_ready("t1_grant", 2'b01);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk); #1;
        check("t1_dv_div_signed", {62'd0, bus.dv_div, bus.dv_signed}, 64'b10);
        check("t1_dv_ops", {bus.dv_x, bus.dv_y}, {32'd100, 32'd7});
        wait_sb_empty("t1_done");
        check("t1_one_issue", 64'(n_acc), 64'd1);

        // 2: signed -7/2 on lane 1
        drive(1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        bus.req_valid = 2'b10;
        push_exp(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        wait_ready("t2_grant", 2'b10);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk); #1;
        check("t2_dv_signed", {63'd0, bus.dv_signed}, 64'd1);
        wait_sb_empty("t2_done");

        // 3: both lanes valid from reset, grants must alternate 1,0,1,0
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        drive(0, 1'b0, 32'd50, 32'd5);
        drive(1, 1'b0, 32'd9, 32'd4);
        push_exp(1'b1, 32'd2, 32'd1);
        push_exp(1'b0, 32'd10, 32'd0);
        push_exp(1'b1, 32'd333, 32'd1);
        push_exp(1'b0, 32'd10, 32'd1);
        bus.req_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_ready($sformatf("t3_grant%0d", g), (g % 2 == 0) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            if (g == 0) drive(1, 1'b0, 32'd1000, 32'd3);
            else if (g == 1) drive(0, 1'b0, 32'd51, 32'd5);
            else bus.req_valid[(g % 2 == 0) ? 1 : 0] = 1'b0;
            @(negedge clk);
        end
        wait_sb_empty("t3_done");

        // 4: flush owner 5 cycles after acceptance; result discarded
        @(negedge clk); #1;
        drive(0, 1'b0, 32'd1234, 32'd10);
        bus.req_valid = 2'b01;
        wait_ready("t4_grant0", 2'b01);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk); #1;
        check("t4_issue", {63'd0, bus.dv_div}, 64'd1);
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 bus.req_flush = 2'b01;
        @(posedge clk); #1 bus.req_flush = '0;
        snap = n_cmp;
        drive(1, 1'b0, 32'd20, 32'd6);
        bus.req_valid = 2'b10;
        push_exp(1'b1, 32'd3, 32'd2);
        wait_ready("t4_grant1", 2'b10);
        check("t4_grant_after_complete", 64'(n_cmp), 64'(snap + 1));
        @(posedge clk); #1 bus.req_valid = '0;
        wait_sb_empty("t4_done");

        // 5: consumer stalls 10 cycles; then reset in the middle of WAIT
        @(posedge clk); #1 bus.resp_ready = 1'b0;
        @(negedge clk); #1;
        drive(0, 1'b0, 32'd77, 32'd10);
        bus.req_valid = 2'b01;
        push_exp(1'b0, 32'd7, 32'd7);
        wait_ready("t5_grant0", 2'b01);
        @(posedge clk); #1;
        drive(1, 1'b0, 32'd300, 32'd7);
        bus.req_valid = 2'b10;
        push_exp(1'b1, 32'd42, 32'd6);
        wait_resp_valid("t5_resp_seen");
        for (int c = 0; c < 10; c++) begin
            check("t5_hold_ctl", {60'd0, bus.resp_valid, bus.resp_id, bus.req_ready}, 64'b1000);
            check("t5_hold_qr", {bus.resp_q, bus.resp_r}, {32'd7, 32'd7});
            @(negedge clk); #1;
        end
        @(posedge clk); #1 bus.resp_ready = 1'b1;
        wait_ready("t5_grant1", 2'b10);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk); #1;
        check("t5_issue1", {bus.dv_x, bus.dv_y}, {32'd300, 32'd7});
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("t5_rst_mid_wait");
        sb.delete();
        @(negedge clk); rst = 1'b0;
        repeat (60) @(negedge clk);
        #1 check("t5_quiet_after_rst", {63'd0, bus.resp_valid}, 64'd0);

        // 6: divide by zero
        snap = n_acc;
        drive(0, 1'b0, 32'd5, 32'd0);
        bus.req_valid = 2'b01;
        push_exp(1'b0, 32'hFFFF_FFFF, 32'd5);
        wait_ready("t6_grant", 2'b01);
        @(posedge clk); #1 bus.req_valid = '0;
        @(negedge clk); #1;
`ifdef DIV_ZERO_BYPASS_EN
        check("t6_resp_t1", {62'd0, bus.resp_valid, bus.dv_div}, 64'b10);
        wait_sb_empty("t6_done");
        check("t6_no_issue", 64'(n_acc), 64'(snap));
`else
        check("t6_issued", {62'd0, bus.resp_valid, bus.dv_div}, 64'b01);
        wait_sb_empty("t6_done");
        check("t6_one_issue", 64'(n_acc), 64'(snap + 1));
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
